// File: rtl/prog_loader.sv
// prog_loader: serial program loader and writable program store for the
// 1-bit processor core. Replaces the fixed program ROM upstream of decode.
//
// A program arrives over a 3-wire serial link (ld_en frames the transfer,
// ld_sclk is the bit clock, ld_sdi carries data MSB first, 8 bits per word).
// All three inputs are asynchronous and are synchronised into clk.
// While a load is in progress the core is held in reset via core_rst.
//
// Ports:
//   clk, rst          system clock, async active-high reset
//   ld_en             load frame (async)
//   ld_sclk, ld_sdi   serial bit clock / data (async)
//   pc_addr [N-1:0]   program counter address
//   instruction[7:0]  mem[pc_addr], combinational read
//   core_rst          reset to PC/control; rst | (state != RUN)
//   ld_done           1-cycle pulse on successful load
//   ld_err            sticky error, cleared on load start or rst
//
// Build option: define PROG_DEFAULT_EN to reset mem to DEFAULT_PROG and
// start in RUN, so the core runs a built-in program without a serial load.
module prog_loader #(
  parameter int                      N            = 2,
  parameter int                      SYNC_STAGES  = 2,
  parameter logic [8*(2**N)-1:0]     DEFAULT_PROG = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_en,
  input  logic         ld_sclk,
  input  logic         ld_sdi,
  input  logic [N-1:0] pc_addr,
  output logic [7:0]   instruction,
  output logic         core_rst,
  output logic         ld_done,
  output logic         ld_err
);

  localparam int DEPTH = 2**N;
  // wcnt value meaning "every word already written"
  localparam logic [N:0] WFULL = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

`ifdef PROG_DEFAULT_EN
  localparam state_t                  RST_STATE = RUN;
  localparam logic [DEPTH-1:0][7:0]   RST_MEM   = DEFAULT_PROG;
`else
  localparam state_t                  RST_STATE = IDLE;
  localparam logic [DEPTH-1:0][7:0]   RST_MEM   = '0;
`endif

  state_t                state;
  logic [DEPTH-1:0][7:0] mem;
  logic [6:0]            shift;
  logic [2:0]            bitcnt;
  logic [N:0]            wcnt;

  // ---------------------------------------------------------------------
  // Input synchronisers followed by one edge-detect flop. An input edge
  // acts on the (SYNC_STAGES+1)th clk edge after it.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] en_s, sclk_s, sdi_s;
  logic                   en_q, sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s   <= '0;
      sclk_s <= '0;
      sdi_s  <= '0;
      en_q   <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      en_s   <= {en_s[SYNC_STAGES-2:0],   ld_en};
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], ld_sclk};
      sdi_s  <= {sdi_s[SYNC_STAGES-2:0],  ld_sdi};
      en_q   <= en_s[SYNC_STAGES-1];
      sclk_q <= sclk_s[SYNC_STAGES-1];
    end
  end

  logic en_rise, en_fall, sclk_rise, sdi_bit;
  assign en_rise   =  en_s[SYNC_STAGES-1]   & ~en_q;
  assign en_fall   = ~en_s[SYNC_STAGES-1]   &  en_q;
  assign sclk_rise =  sclk_s[SYNC_STAGES-1] & ~sclk_q;
  // sdi shares the sclk latency, so it is the bit that was stable at the rise
  assign sdi_bit   =  sdi_s[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Load FSM and program store
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RST_STATE;
      mem     <= RST_MEM;
      shift   <= '0;
      bitcnt  <= '0;
      wcnt    <= '0;
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      if (en_rise) begin
        // a new frame restarts the load from any state
        state  <= LOAD;
        bitcnt <= '0;
        wcnt   <= '0;
        ld_err <= 1'b0;
      end else if (state == LOAD) begin
        if (en_fall) begin
          if (ld_err) begin
            state <= IDLE;
          end else if (bitcnt == 3'd0 && wcnt != '0) begin
            state   <= RUN;
            ld_done <= 1'b1;
          end else begin
            // partial trailing word or empty frame; partial bits are dropped
            state  <= IDLE;
            ld_err <= 1'b1;
          end
        end else if (sclk_rise) begin
          shift <= {shift[5:0], sdi_bit};
          if (bitcnt == 3'd7) begin
            bitcnt <= '0;
            if (wcnt == WFULL) begin
              // store full: discard the word, no wrap
              ld_err <= 1'b1;
            end else begin
              mem[wcnt[N-1:0]] <= {shift, sdi_bit};
              wcnt             <= wcnt + 1'b1;
            end
          end else begin
            bitcnt <= bitcnt + 3'd1;
          end
        end
      end
    end
  end

  assign instruction = mem[pc_addr];
  assign core_rst    = rst | (state != RUN);

endmodule
